// File: rtl/toy_pkg.sv
// Shared definitions for the toy processor control unit: opcodes, sequencer
// states, ALU operation codes and instruction-length decode.
package toy_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_JMP   = 4'h5;
    localparam logic [3:0] OP_JZ    = 4'h6;
    localparam logic [3:0] OP_OUT   = 4'h7;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_OPFETCH = 3'd2,
        ST_OPLATCH = 3'd3,
        ST_EXEC    = 3'd4,
        ST_WB      = 3'd5
    } state_t;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    // Opcodes LOAD..JZ carry an operand-address byte after the opcode byte.
    function automatic logic is_two_byte(input logic [3:0] opcode);
        return (opcode >= OP_LOAD) && (opcode <= OP_JZ);
    endfunction

endpackage

// File: rtl/toy_pc_reg.sv
// Program counter: synchronous reset, parallel load (priority) and increment.
module toy_pc_reg #(
    parameter int               ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] load_value,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            pc_reg <= RESET_PC;
        end else if (load) begin
            pc_reg <= load_value;
        end else if (inc) begin
            pc_reg <= pc_reg + ADDR_W'(1);
        end
    end

    assign pc = pc_reg;

endmodule

// File: rtl/toy_control_unit.sv
// Six-state fetch/decode/execute sequencer for the toy processor; outputs are
// decoded from registered state only, with memory/load strobes gated by RESET.
module toy_control_unit
    import toy_pkg::*;
#(
    parameter int               ADDR_W   = 8,
    parameter int               DATA_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] D_IN,
    input  logic              ZERO,
    output logic [ADDR_W-1:0] ADDR,
    output logic              RW,
    output logic              MEM_EN,
    output logic              S0,
    output logic              S1,
    output logic              S2,
    output logic              S3,
    output logic              S4,
    output logic              S5,
    output logic [1:0]        ALU_OP,
    output logic              ACC_LD,
    output logic              OUT_LD,
    output logic              HALTED
);

    state_t            state_reg, state_next;
    logic [3:0]        opcode_reg;
    logic [ADDR_W-1:0] opr_reg;
    logic              halted_reg;
    logic [ADDR_W-1:0] pc;
    logic              pc_load, pc_inc;
    logic [ADDR_W-1:0] addr_next;
    logic              rw_next, mem_en_next, acc_ld_next, out_ld_next;
    logic [1:0]        alu_op_next;
    logic [3:0]        d_op;
    logic [5:0]        strobe;

    // Only the opcode nibble of IR has any meaning to the sequencer.
    assign d_op = D_IN[7:4];

    toy_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (CLK),
        .srst       (RESET),
        .load       (pc_load),
        .inc        (pc_inc),
        .load_value (D_IN[ADDR_W-1:0]),
        .pc         (pc)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg  <= ST_FETCH;
            opcode_reg <= '0;
            opr_reg    <= '0;
            halted_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_DECODE) begin
                opcode_reg <= d_op;
            end
            if (state_reg == ST_OPLATCH) begin
                opr_reg <= D_IN[ADDR_W-1:0];
            end
            if (state_reg == ST_WB && opcode_reg == OP_HALT) begin
                halted_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_load     = 1'b0;
        pc_inc      = 1'b0;
        addr_next   = pc;
        rw_next     = 1'b1;
        mem_en_next = 1'b0;
        acc_ld_next = 1'b0;
        out_ld_next = 1'b0;
        alu_op_next = ALU_PASS;
        case (state_reg)
            ST_FETCH: begin
                mem_en_next = 1'b1;
                state_next  = ST_DECODE;
            end
            ST_DECODE: begin
                pc_inc     = 1'b1;
                state_next = is_two_byte(d_op) ? ST_OPFETCH : ST_WB;
            end
            ST_OPFETCH: begin
                mem_en_next = 1'b1;
                state_next  = ST_OPLATCH;
            end
            ST_OPLATCH: begin
                if (opcode_reg == OP_JMP || (opcode_reg == OP_JZ && ZERO)) begin
                    pc_load    = 1'b1;
                    state_next = ST_FETCH;
                end else begin
                    pc_inc     = 1'b1;
                    state_next = (opcode_reg == OP_JZ) ? ST_FETCH : ST_EXEC;
                end
            end
            ST_EXEC: begin
                addr_next   = opr_reg;
                mem_en_next = 1'b1;
                rw_next     = (opcode_reg != OP_STORE);
                state_next  = ST_WB;
            end
            ST_WB: begin
                case (opcode_reg)
                    OP_LOAD: acc_ld_next = 1'b1;
                    OP_ADD: begin
                        acc_ld_next = 1'b1;
                        alu_op_next = ALU_ADD;
                    end
                    OP_SUB: begin
                        acc_ld_next = 1'b1;
                        alu_op_next = ALU_SUB;
                    end
                    OP_OUT:  out_ld_next = 1'b1;
                    default: ;
                endcase
                // HALT parks here; only RESET leaves.
                state_next = (opcode_reg == OP_HALT) ? ST_WB : ST_FETCH;
            end
            default: state_next = ST_FETCH;
        endcase
    end

    for (genvar gi = 0; gi < 6; gi++) begin : g_strobe
        assign strobe[gi] = RESET ? (gi == 0) : (state_reg == 3'(gi));
    end

    assign {S5, S4, S3, S2, S1, S0} = strobe;
    assign ADDR   = RESET ? pc : addr_next;
    assign RW     = RESET | rw_next;
    assign MEM_EN = ~RESET & mem_en_next;
    assign ACC_LD = ~RESET & acc_ld_next;
    assign OUT_LD = ~RESET & out_ld_next;
    assign ALU_OP = RESET ? ALU_PASS : alu_op_next;
    assign HALTED = halted_reg;

endmodule

// File: tb/tb_toy_control_unit.sv
// Scoreboard bench for toy_control_unit: expected per-cycle outputs are queued
// when a program is loaded and compared as the sequencer steps through it.
module tb_toy_control_unit;

    typedef enum int {F_ADDR, F_RW, F_MEN, F_ACC, F_OUT, F_ALU, F_HALT, F_STATE} field_e;
    typedef struct {
        int         cyc;
        string      tag;
        field_e     fld;
        logic [7:0] val;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       ZERO = 1'b0;
    logic [7:0] d_in = 8'h00;
    logic       sel_w = 1'b0;
    logic [7:0] mem [256];

    logic [7:0] a_addr, w_addr;
    logic       a_rw, a_men, a_acc, a_out, a_halt, w_rw, w_men, w_acc, w_out, w_halt;
    logic [1:0] a_alu, w_alu;
    logic [5:0] a_st, w_st;

    logic [7:0] o_addr;
    logic       o_rw, o_men;
    logic [5:0] o_state;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    toy_control_unit #(.ADDR_W(8), .DATA_W(8), .RESET_PC(8'h00)) dut (
        .CLK(CLK), .RESET(RESET), .D_IN(d_in), .ZERO(ZERO),
        .ADDR(a_addr), .RW(a_rw), .MEM_EN(a_men),
        .S0(a_st[0]), .S1(a_st[1]), .S2(a_st[2]), .S3(a_st[3]), .S4(a_st[4]), .S5(a_st[5]),
        .ALU_OP(a_alu), .ACC_LD(a_acc), .OUT_LD(a_out), .HALTED(a_halt)
    );

    toy_control_unit #(.ADDR_W(8), .DATA_W(8), .RESET_PC(8'hFF)) dut_w (
        .CLK(CLK), .RESET(RESET), .D_IN(d_in), .ZERO(ZERO),
        .ADDR(w_addr), .RW(w_rw), .MEM_EN(w_men),
        .S0(w_st[0]), .S1(w_st[1]), .S2(w_st[2]), .S3(w_st[3]), .S4(w_st[4]), .S5(w_st[5]),
        .ALU_OP(w_alu), .ACC_LD(w_acc), .OUT_LD(w_out), .HALTED(w_halt)
    );

    assign o_addr  = sel_w ? w_addr : a_addr;
    assign o_rw    = sel_w ? w_rw : a_rw;
    assign o_men   = sel_w ? w_men : a_men;
    assign o_state = sel_w ? w_st : a_st;

    always #5 CLK = ~CLK;

    // Memory read data appears one cycle after a read strobe.
    always @(posedge CLK) begin
        if (o_men && o_rw) d_in <= mem[o_addr];
    end

    function automatic logic [7:0] observe(field_e f);
        case (f)
            F_ADDR:  return o_addr;
            F_RW:    return {7'd0, o_rw};
            F_MEN:   return {7'd0, o_men};
            F_ACC:   return {7'd0, sel_w ? w_acc : a_acc};
            F_OUT:   return {7'd0, sel_w ? w_out : a_out};
            F_ALU:   return {6'd0, sel_w ? w_alu : a_alu};
            F_HALT:  return {7'd0, sel_w ? w_halt : a_halt};
            default: return {2'd0, o_state};
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end else begin
            $display("ok   %s observed=%h", tag, obs);
        end
    endtask

    task automatic push(input int c, input string t, input field_e f, input logic [7:0] v);
        exp_t e;
        e.cyc = c; e.tag = t; e.fld = f; e.val = v;
        sb.push_back(e);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic do_reset(input logic [7:0] rst_pc);
        RESET = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            if (i < 2) begin
                @(negedge CLK);
                check_val($sformatf("rst%0d_s0", i), {2'd0, o_state}, 8'h01);
                check_val($sformatf("rst%0d_men", i), {7'd0, o_men}, 8'h00);
                check_val($sformatf("rst%0d_addr", i), o_addr, rst_pc);
            end
        end
        #1 RESET = 1'b0;
    endtask

    // Step ncyc cycles from the first post-reset cycle; rst_cyc < ncyc pulses RESET in that cycle.
    task automatic run(input int ncyc, input int rst_cyc);
        exp_t e;
        for (int c = 0; c < ncyc; c++) begin
            if (c == rst_cyc) RESET = 1'b1;
            @(negedge CLK);
            check_val($sformatf("c%0d_onehot", c), 8'($countones(o_state)), 8'd1);
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                check_val(e.tag, observe(e.fld), e.val);
            end
            @(posedge CLK);
            #1;
            if (c == rst_cyc) RESET = 1'b0;
        end
        if (sb.size() != 0) begin
            check_val("sb_drain", 8'(sb.size()), 8'd0);
            sb.delete();
        end
    endtask

    initial begin
        // LOAD / ADD / OUT / HALT program
        clear_mem();
        mem[8'h00] = 8'h10; mem[8'h01] = 8'h20; mem[8'h02] = 8'h30; mem[8'h03] = 8'h21;
        mem[8'h04] = 8'h70; mem[8'h05] = 8'hF0; mem[8'h20] = 8'h05; mem[8'h21] = 8'h03;
        push(0, "p_c0_addr", F_ADDR, 8'h00);
        push(0, "p_c0_men", F_MEN, 8'h01);
        push(0, "p_c0_rw", F_RW, 8'h01);
        push(1, "p_c1_men", F_MEN, 8'h00);
        push(4, "p_c4_addr", F_ADDR, 8'h20);
        push(5, "p_c5_acc", F_ACC, 8'h01);
        push(5, "p_c5_alu", F_ALU, 8'h00);
        push(10, "p_c10_addr", F_ADDR, 8'h21);
        push(10, "p_c10_alu", F_ALU, 8'h00);
        push(11, "p_c11_acc", F_ACC, 8'h01);
        push(11, "p_c11_alu", F_ALU, 8'h01);
        push(12, "p_c12_addr", F_ADDR, 8'h04);
        push(14, "p_c14_out", F_OUT, 8'h01);
        push(14, "p_c14_acc", F_ACC, 8'h00);
        push(15, "p_c15_addr", F_ADDR, 8'h05);
        push(17, "p_c17_state", F_STATE, 8'h20);
        push(17, "p_c17_halt", F_HALT, 8'h00);
        for (int c = 18; c < 22; c++) begin
            push(c, $sformatf("p_c%0d_halt", c), F_HALT, 8'h01);
            push(c, $sformatf("p_c%0d_state", c), F_STATE, 8'h20);
            push(c, $sformatf("p_c%0d_men", c), F_MEN, 8'h00);
        end
        do_reset(8'h00);
        run(22, -1);

        // STORE
        clear_mem();
        mem[8'h00] = 8'h20; mem[8'h01] = 8'h40;
        push(4, "st_c4_addr", F_ADDR, 8'h40);
        push(4, "st_c4_rw", F_RW, 8'h00);
        push(4, "st_c4_men", F_MEN, 8'h01);
        push(5, "st_c5_acc", F_ACC, 8'h00);
        push(5, "st_c5_state", F_STATE, 8'h20);
        push(6, "st_c6_addr", F_ADDR, 8'h02);
        do_reset(8'h00);
        run(7, -1);

        // JZ taken, JZ not taken, JMP
        clear_mem();
        mem[8'h00] = 8'h60; mem[8'h01] = 8'h10;
        ZERO = 1'b1;
        push(3, "jz1_c3_state", F_STATE, 8'h08);
        push(4, "jz1_c4_addr", F_ADDR, 8'h10);
        push(4, "jz1_c4_state", F_STATE, 8'h01);
        do_reset(8'h00);
        run(5, -1);
        ZERO = 1'b0;
        push(4, "jz0_c4_addr", F_ADDR, 8'h02);
        push(4, "jz0_c4_state", F_STATE, 8'h01);
        do_reset(8'h00);
        run(5, -1);
        mem[8'h00] = 8'h50; mem[8'h01] = 8'h77;
        push(4, "jmp_c4_addr", F_ADDR, 8'h77);
        do_reset(8'h00);
        run(5, -1);

        // Undefined opcode behaves as a one-byte NOP
        clear_mem();
        mem[8'h00] = 8'h8A;
        push(2, "nop8_c2_state", F_STATE, 8'h20);
        push(2, "nop8_c2_acc", F_ACC, 8'h00);
        push(3, "nop8_c3_addr", F_ADDR, 8'h01);
        do_reset(8'h00);
        run(4, -1);

        // Mid-instruction reset during STORE's execute cycle
        clear_mem();
        mem[8'h00] = 8'h20; mem[8'h01] = 8'h40;
        push(4, "mr_c4_men", F_MEN, 8'h00);
        push(4, "mr_c4_rw", F_RW, 8'h01);
        push(4, "mr_c4_state", F_STATE, 8'h01);
        push(5, "mr_c5_state", F_STATE, 8'h01);
        push(5, "mr_c5_addr", F_ADDR, 8'h00);
        push(5, "mr_c5_men", F_MEN, 8'h01);
        push(6, "mr_c6_state", F_STATE, 8'h02);
        do_reset(8'h00);
        run(7, 4);

        // PC wrap with RESET_PC = FF
        clear_mem();
        mem[8'hFF] = 8'h50; mem[8'h00] = 8'h33;
        sel_w = 1'b1;
        push(0, "wr_c0_addr", F_ADDR, 8'hFF);
        push(2, "wr_c2_addr", F_ADDR, 8'h00);
        push(4, "wr_c4_addr", F_ADDR, 8'h33);
        push(4, "wr_c4_state", F_STATE, 8'h01);
        do_reset(8'hFF);
        run(5, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
